// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU: operation codes, controller
// states and the result-width derivation used by every file of the block.
package alu_pkg;

    localparam logic [2:0] FN_MUL   = 3'b000;
    localparam logic [2:0] FN_SHR   = 3'b001;
    localparam logic [2:0] FN_SHL   = 3'b010;
    localparam logic [2:0] FN_RED   = 3'b011;
    localparam logic [2:0] FN_LOGIC = 3'b100;
    localparam logic [2:0] FN_SUB   = 3'b101;
    localparam logic [2:0] FN_ADD   = 3'b110;
    localparam logic [2:0] FN_INC   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int accWidth(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles
// per product. valid marks the cycle whose combinational product is final.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int ACC_W = accWidth(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [ACC_W-1:0] product,
    output logic             valid
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [ACC_W-1:0] mcand_q;
    logic [ACC_W-1:0] mcand_d;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] mplier_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             busy_q;
    logic             busy_d;
    logic             lastStep;

    // The last iteration's sum is handed out directly so the caller can
    // capture the product on the same edge that retires the multiplier.
    always_comb begin
        lastStep = busy_q && (count_q == CNT_W'(1));
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        busy_d   = busy_q;
        if (load) begin
            mcand_d  = ACC_W'(b);
            mplier_d = a;
            count_d  = CNT_W'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CNT_W'(1);
            busy_d   = !lastStep;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= load ? '0 : (busy_q ? acc_d : acc_q);
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign product = acc_d;
    assign valid   = lastStep;

endmodule

// File: rtl/param_accum_alu.sv
// Accumulator ALU: WIDTH-bit operand against the low half of a 2*WIDTH-bit
// registered result, with start/busy/done handshake and carry/zero flags.
module param_accum_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int ACC_W = accWidth(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic             carry,
    output logic             zero
);

    state_e           state_q;
    state_e           state_d;
    logic [ACC_W-1:0] result_q;
    logic [ACC_W-1:0] result_d;
    logic             carry_q;
    logic             carry_d;
    logic             zero_q;
    logic             zero_d;

    logic [WIDTH-1:0] accLo;
    logic [ACC_W-1:0] aWide;
    logic [ACC_W-1:0] bWide;
    logic [WIDTH:0]   sumAdd;
    logic [WIDTH:0]   sumInc;
    logic [ACC_W-1:0] aluResult;
    logic             aluCarry;

    logic             mulLoad;
    logic             mulBusy;
    logic             mulValid;
    logic [ACC_W-1:0] mulProduct;

    assign accLo  = result_q[WIDTH-1:0];
    assign aWide  = ACC_W'(data);
    assign bWide  = ACC_W'(accLo);
    assign sumAdd = {1'b0, data} + {1'b0, accLo};
    assign sumInc = {1'b0, data} + {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle operations; shift amounts past the operand range give zero.
    always_comb begin
        aluResult = '0;
        aluCarry  = 1'b0;
        case (func)
            FN_INC: begin
                aluResult = ACC_W'(sumInc);
                aluCarry  = sumInc[WIDTH];
            end
            FN_ADD: begin
                aluResult = ACC_W'(sumAdd);
                aluCarry  = sumAdd[WIDTH];
            end
            FN_SUB: begin
                aluResult = aWide - bWide;
                aluCarry  = (data < accLo);
            end
            FN_LOGIC: aluResult = {data | accLo, data ^ accLo};
            FN_RED:   aluResult = {{(ACC_W-1){1'b0}}, (|data) | (|accLo)};
            FN_SHL:   aluResult = (aWide >= ACC_W'(ACC_W)) ? '0 : (bWide << aWide);
            FN_SHR:   aluResult = (data >= WIDTH'(WIDTH)) ? '0 : (bWide >> aWide);
            default:  aluResult = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        mulLoad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (func == FN_MUL) begin
                        mulLoad = 1'b1;
                        state_d = MUL;
                    end else begin
                        result_d = aluResult;
                        carry_d  = aluCarry;
                        zero_d   = (aluResult == '0);
                        state_d  = DONE;
                    end
                end
            end
            MUL: begin
                if (mulValid) begin
                    result_d = mulProduct;
                    carry_d  = 1'b0;
                    zero_d   = (mulProduct == '0);
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    seq_multiplier #(.WIDTH(WIDTH)) uMult (
        .clk     (clk),
        .reset   (reset),
        .load    (mulLoad),
        .a       (data),
        .b       (accLo),
        .busy    (mulBusy),
        .product (mulProduct),
        .valid   (mulValid)
    );

    assign busy   = mulBusy;
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_param_accum_alu.sv
// Scoreboard bench for param_accum_alu (WIDTH=4): stimulus queues expected
// responses, a negedge monitor checks them whenever done is raised.
module tb_param_accum_alu;

    localparam int WIDTH = 4;
    localparam int ACC_W = 8;

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             carry;
        logic             zero;
        int               cyc;
        bit               isMul;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       func;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] result;
    logic             carry;
    logic             zero;

    exp_t sbq[$];
    int   cycCount   = 0;
    int   busyRun    = 0;
    int   passChecks = 0;
    int   totalChecks = 0;

    param_accum_alu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .func   (func),
        .data   (data),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycCount <= cycCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) passChecks++;
        else $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Monitor: pops one expectation for every done pulse
    always @(negedge clk) begin
        if (reset) begin
            busyRun = 0;
        end else begin
            if (busy) busyRun++;
            if (done) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpectedDone", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("result",    32'(result), 32'(e.res));
                    checkOutput("carry",     32'(carry),  32'(e.carry));
                    checkOutput("zero",      32'(zero),   32'(e.zero));
                    checkOutput("doneCycle", 32'(cycCount), 32'(e.cyc));
                    if (e.isMul) checkOutput("busyCycles", 32'(busyRun), 32'(WIDTH));
                end
                busyRun = 0;
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rstResult", 32'(result), 32'd0);
        checkOutput("rstBusy",   32'(busy),   32'd0);
        checkOutput("rstDone",   32'(done),   32'd0);
    endtask

    task automatic issueOp(input logic [2:0] f, input logic [WIDTH-1:0] d,
                           input logic [ACC_W-1:0] r, input logic c, input logic z,
                           input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        func  = f;
        data  = d;
        if (push) begin
            e.res   = r;
            e.carry = c;
            e.zero  = z;
            e.isMul = (f == 3'b000);
            e.cyc   = cycCount + 1 + (e.isMul ? WIDTH : 0);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checkOutput("doneTimeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [2:0] f, input logic [WIDTH-1:0] d,
                                 input logic [ACC_W-1:0] r, input logic c, input logic z);
        issueOp(f, d, r, c, z, 1'b1);
        waitDone();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        func  = 3'b000;
        data  = '0;

        // 1: add and add with carry
        doReset();
        checkOutput("rstCarry", 32'(carry), 32'd0);
        checkOutput("rstZero",  32'(zero),  32'd0);
        applyStimulus(3'b110, 4'd5,  8'h05, 1'b0, 1'b0);
        applyStimulus(3'b110, 4'd12, 8'h11, 1'b1, 1'b0);

        // 2: multiply 7*9 with an ignored start during busy
        doReset();
        applyStimulus(3'b110, 4'd9, 8'h09, 1'b0, 1'b0);
        issueOp(3'b000, 4'd7, 8'h3F, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        func  = 3'b110;
        data  = 4'd1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone();
        repeat (3) @(negedge clk);
        checkOutput("mulHoldResult", 32'(result), 32'h3F);
        checkOutput("mulHoldDone",   32'(done),   32'd0);

        // 3: subtract with borrow, then to zero
        doReset();
        applyStimulus(3'b110, 4'd3,  8'h03, 1'b0, 1'b0);
        applyStimulus(3'b101, 4'd2,  8'hFF, 1'b1, 1'b0);
        applyStimulus(3'b101, 4'd15, 8'h00, 1'b0, 1'b1);

        // 4: shift left, then shift past the result width
        doReset();
        applyStimulus(3'b110, 4'd9, 8'h09, 1'b0, 1'b0);
        applyStimulus(3'b010, 4'd3, 8'h48, 1'b0, 1'b0);
        applyStimulus(3'b010, 4'd9, 8'h00, 1'b0, 1'b1);

        // 5: logic, reduce and a shift right beyond the operand width
        doReset();
        applyStimulus(3'b100, 4'd0, 8'h00, 1'b0, 1'b1);
        applyStimulus(3'b110, 4'd6, 8'h06, 1'b0, 1'b0);
        applyStimulus(3'b100, 4'd3, 8'h75, 1'b0, 1'b0);
        applyStimulus(3'b011, 4'd0, 8'h01, 1'b0, 1'b0);
        applyStimulus(3'b110, 4'd12, 8'h0D, 1'b0, 1'b0);
        applyStimulus(3'b001, 4'd2,  8'h03, 1'b0, 1'b0);
        applyStimulus(3'b001, 4'd4,  8'h00, 1'b0, 1'b1);

        // 6: reset aborts a multiply in flight
        doReset();
        applyStimulus(3'b110, 4'd9, 8'h09, 1'b0, 1'b0);
        issueOp(3'b000, 4'd7, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy",   32'(busy),   32'd0);
        checkOutput("abortDone",   32'(done),   32'd0);
        checkOutput("abortResult", 32'(result), 32'd0);
        repeat (6) @(negedge clk);
        checkOutput("abortNoDone", 32'(done), 32'd0);
        applyStimulus(3'b111, 4'd15, 8'h10, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule

// File: doc/param_accum_alu.md
Name: param_accum_alu

Overview:
Parametrised successor to the 4-bit register ALU. It is an accumulator ALU with a WIDTH-bit data operand and a 2*WIDTH-bit registered result. The low WIDTH bits of the result feed back as the second operand. It adds start/busy/done handshaking, carry/borrow and zero flags, a subtract op, and a multi-cycle shift-add multiplier in place of the combinational multiply. It sits between the switch/key input layer and the LEDR/HEX display decoders.

Parameters:
WIDTH, 4, data operand width; the accumulator feedback operand acc_lo = result[WIDTH-1:0].
ACC_W, 2*WIDTH, result width (derived; not overridable).

Ports:
clk  in  1  single clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request an operation; sampled only in IDLE.
func  in  3  operation code; sampled with start.
data  in  WIDTH  operand A; sampled with start.
busy  out  1  high while a multiply is executing.
done  out  1  one-cycle pulse when result/flags update.
result  out  ACC_W  registered result, also the accumulator.
carry  out  1  carry out (add/inc) or borrow (sub); 0 for other ops.
zero  out  1  high when result == 0, registered with result.

Behaviour:
- Reset (synchronous, active-high):
  - On a clk edge with reset=1: result=0, carry=0, zero=0, busy=0, done=0, state=IDLE, mult counter=0.
  - reset overrides start. Reset mid-multiply aborts it: no done, result=0.
- States: IDLE, MUL, DONE.
  - IDLE + start, func!=000 -> DONE. result/flags written at that edge.
  - IDLE + start, func==000 -> MUL. Operands captured.
  - MUL runs WIDTH iterations, then -> DONE.
  - DONE -> IDLE after one cycle.
- done is high exactly while in DONE.
- start is ignored in MUL and DONE: no queueing, no effect on the operation in flight.
- Latency, with start sampled at edge N:
  - Single-cycle ops: result valid and done=1 in cycle N+1.
  - Multiply: busy=1 in cycles N+1..N+WIDTH; result valid and done=1 in cycle N+WIDTH+1.
- Operands are captured at start: A=data, B=acc_lo snapshot. The multiply uses the snapshot only.
- Func codes (all results zero-extended to ACC_W):
  - 111 inc: A+1; carry = bit WIDTH of the sum.
  - 110 add: A+B; carry = bit WIDTH of the sum.
  - 101 sub: A-B in ACC_W two's complement; carry = borrow (A<B).
  - 100 logic: {A|B, A^B}, upper WIDTH bits = OR, lower = XOR.
  - 011 reduce: 1 if any bit of A or B is set, else 0.
  - 010 shl: B<<A computed at ACC_W; A>=ACC_W gives 0.
  - 001 shr: B>>A; A>=WIDTH gives 0.
  - 000 mul: unsigned A*B via shift-add, one partial product per cycle; exact ACC_W-bit product; carry=0.
- Flags:
  - zero and carry update only at the edge that writes result.
  - Between operations, result, carry and zero hold their values.

Decomposition:
- Shared package alu_pkg holds:
  - func code constants FN_MUL, FN_SHR, FN_SHL, FN_RED, FN_LOGIC, FN_SUB, FN_ADD, FN_INC;
  - state enum IDLE/MUL/DONE;
  - the ACC_W derivation function.
- One sub-module: seq_multiplier(WIDTH).
  - Inputs: load, a, b.
  - Outputs: busy, product, valid.
  - Internals: shift-add datapath plus iteration counter.
- The top holds the FSM, the single-cycle datapath and the flag registers.

Test Plan (WIDTH=4):
1. Reset, then start func=110 data=5 -> done in cycle N+1, result=0x05, carry=0, zero=0. Then add data=12 -> result=0x11, carry=1.
2. Reset, add data=9, then start func=000 data=7 -> busy high exactly 4 cycles, done at N+5, result=0x3F. A start pulse during busy leaves result=0x3F and produces no extra done.
3. Reset, add data=3, then sub data=2 -> result=0xFF, carry=1. Then sub data=15 (acc_lo=0xF) -> result=0x00, zero=1, carry=0.
4. Reset, add data=9, then shl data=3 -> result=0x48. Then shl data=9 (acc_lo=8) -> result=0x00, zero=1.
5. Reset, logic data=0 -> result=0, zero=1. Add data=6, then logic data=3 -> result=0x75. Then reduce data=0 -> result=0x01.
6. Reset, add data=9, start mul data=7, assert reset at N+2 -> no done, busy=0 next cycle, result=0. A following inc data=15 -> result=0x10, carry=1.
